hdmi_packet_serializer: RTL and testbench

HDMI_PACKET_SERIALIZER -- requirements
Module: hdmi_packet_serializer

---
 rtl/hdmi_pkg.sv | 20 ++
 rtl/hdmi_packet_serializer_if.sv | 24 ++
 rtl/bch_ecc_step.sv | 20 ++
 rtl/hdmi_packet_serializer.sv | 98 +++++++++
 tb/tb_hdmi_packet_serializer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/hdmi_pkg.sv
// Shared constants and bus types for the HDMI data-island packet serializer.
package hdmi_pkg;

    localparam int unsigned PACKET_PIXELS      = 32;
    localparam int unsigned HEADER_DATA_PIXELS = 24;
    localparam int unsigned SUB_DATA_PIXELS    = 28;
    localparam int unsigned NUM_SUB            = 4;
    localparam int unsigned HDR_W              = 24;
    localparam int unsigned SUB_W              = 56;
    localparam int unsigned ECC_W              = 8;
    localparam int unsigned CNT_W              = 5;
    localparam int unsigned DATA_W             = 9;

    // Reflected BCH generator 1 + x^6 + x^7 + x^8, applied LSB first.
    localparam logic [ECC_W-1:0] BCH_POLY = 8'h83;

    typedef logic [SUB_W-1:0]              subpacket_t;
    typedef subpacket_t [NUM_SUB-1:0]      sub_bus_t;

endpackage

// File: rtl/hdmi_packet_serializer_if.sv
// Packet bus between the upstream packet source and the serializer.
interface hdmi_packet_serializer_if;
    import hdmi_pkg::*;

    logic                 data_island_period;
    logic [HDR_W-1:0]     header;
    sub_bus_t             sub;
    logic [CNT_W-1:0]     packet_pixel_counter;
    logic                 packet_enable;
    logic [DATA_W-1:0]    packet_data;

    // Upstream side: supplies the packet and island timing.
    modport master (
        output data_island_period, header, sub,
        input  packet_pixel_counter, packet_enable, packet_data
    );

    // Serializer side.
    modport slave (
        input  data_island_period, header, sub,
        output packet_pixel_counter, packet_enable, packet_data
    );

endinterface

// File: rtl/bch_ecc_step.sv
// Advances a BCH ECC accumulator by BITS input bits, bit 0 first.
module bch_ecc_step
    import hdmi_pkg::*;
#(
    parameter int unsigned BITS = 1
) (
    input  logic [ECC_W-1:0] ecc_in,
    input  logic [BITS-1:0]  data_in,
    output logic [ECC_W-1:0] ecc_out
);

    // Serial LFSR update unrolled over BITS bits.
    always_comb begin
        ecc_out = ecc_in;
        for (int unsigned i = 0; i < BITS; i++) begin
            ecc_out = (ecc_out >> 1) ^ ((ecc_out[0] ^ data_in[i]) ? BCH_POLY : '0);
        end
    end

endmodule

// File: rtl/hdmi_packet_serializer.sv
// Serializes one 32-pixel HDMI data-island packet per request, appending BCH ECC.
module hdmi_packet_serializer
    import hdmi_pkg::*;
(
    input  logic                      clk_pixel,
    input  logic                      reset,
    hdmi_packet_serializer_if.slave   bus
);

    logic [CNT_W-1:0]              counter_q, counter_d;
    logic [ECC_W-1:0]              header_ecc_q, header_ecc_d, header_ecc_step;
    logic [NUM_SUB-1:0][ECC_W-1:0] sub_ecc_q, sub_ecc_d, sub_ecc_step;

    logic                          last_pixel_c;
    logic                          hdr_bit_c;
    logic [5:0]                    sub_idx_c;
    logic [2:0]                    sub_ecc_shift_c;
    logic [NUM_SUB-1:0][1:0]       sub_pair_c;

    // Bit selection for the current pixel; shifts keep indices in range past the data phase.
    always_comb begin
        last_pixel_c    = (counter_q == CNT_W'(PACKET_PIXELS - 1));
        hdr_bit_c       = 1'(bus.header >> counter_q);
        sub_idx_c       = {counter_q, 1'b0};
        sub_ecc_shift_c = 3'({2'(counter_q - CNT_W'(SUB_DATA_PIXELS)), 1'b0});
        for (int unsigned k = 0; k < NUM_SUB; k++) begin
            sub_pair_c[k] = 2'(bus.sub[k] >> sub_idx_c);
        end
    end

    bch_ecc_step #(.BITS(1)) u_header_ecc (
        .ecc_in  (header_ecc_q),
        .data_in (hdr_bit_c),
        .ecc_out (header_ecc_step)
    );

    for (genvar k = 0; k < NUM_SUB; k++) begin : g_sub_ecc
        bch_ecc_step #(.BITS(2)) u_sub_ecc (
            .ecc_in  (sub_ecc_q[k]),
            .data_in (sub_pair_c[k]),
            .ecc_out (sub_ecc_step[k])
        );
    end

    // Counter and ECC next-state; reset and island gaps restart the packet from zero.
    always_comb begin
        counter_d    = counter_q;
        header_ecc_d = header_ecc_q;
        sub_ecc_d    = sub_ecc_q;
        if (reset || !bus.data_island_period) begin
            counter_d    = '0;
            header_ecc_d = '0;
            sub_ecc_d    = '0;
        end else begin
            counter_d = counter_q + CNT_W'(1);
            if (last_pixel_c) begin
                header_ecc_d = '0;
                sub_ecc_d    = '0;
            end else begin
                if (counter_q < CNT_W'(HEADER_DATA_PIXELS)) begin
                    header_ecc_d = header_ecc_step;
                end
                if (counter_q < CNT_W'(SUB_DATA_PIXELS)) begin
                    sub_ecc_d = sub_ecc_step;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_pixel) begin
        counter_q    <= counter_d;
        header_ecc_q <= header_ecc_d;
        sub_ecc_q    <= sub_ecc_d;
    end

    // Zero-latency outputs: data bits during the data phase, frozen ECC afterwards.
    always_comb begin
        bus.packet_pixel_counter = counter_q;
        bus.packet_enable        = bus.data_island_period && last_pixel_c && !reset;
        bus.packet_data          = '0;
        if (bus.data_island_period) begin
            bus.packet_data[0] = (counter_q < CNT_W'(HEADER_DATA_PIXELS))
                               ? hdr_bit_c
                               : 1'(header_ecc_q >> (counter_q - CNT_W'(HEADER_DATA_PIXELS)));
            for (int unsigned k = 0; k < NUM_SUB; k++) begin
                if (counter_q < CNT_W'(SUB_DATA_PIXELS)) begin
                    bus.packet_data[1 + k] = sub_pair_c[k][0];
                    bus.packet_data[5 + k] = sub_pair_c[k][1];
                end else begin
                    bus.packet_data[1 + k] = 1'(sub_ecc_q[k] >> sub_ecc_shift_c);
                    bus.packet_data[5 + k] = 1'(sub_ecc_q[k] >> (sub_ecc_shift_c + 3'd1));
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_packet_serializer.sv
// Directed bench for hdmi_packet_serializer with a codeword-level reference model.
module tb_hdmi_packet_serializer;
    import hdmi_pkg::*;

    logic clk_pixel = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   mc = 0;
    bit   mvalid = 1'b0;

    always #5 clk_pixel = ~clk_pixel;

    hdmi_packet_serializer_if bus();

    hdmi_packet_serializer dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ECC of the first n bits of a message, consumed LSB first.
    function automatic logic [7:0] bch(input logic [63:0] msg, input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < n; i++) begin
            e = (e >> 1) ^ ((e[0] ^ msg[i]) ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    // Expected pixel payload: bit c of the header codeword, bits 2c/2c+1 of each sub codeword.
    function automatic logic [8:0] model_data(input int c, input logic [23:0] h, input sub_bus_t s);
        logic [31:0] hcw;
        logic [63:0] scw;
        logic [8:0]  d;
        hcw  = {bch(64'(h), 24), h};
        d    = '0;
        d[0] = hcw[c];
        for (int k = 0; k < 4; k++) begin
            scw      = {bch(64'(s[k]), 56), s[k]};
            d[1 + k] = scw[2 * c];
            d[5 + k] = scw[2 * c + 1];
        end
        return d;
    endfunction

    // Model pixel position: follows the island, restarts on reset or gap.
    always @(posedge clk_pixel) begin
        if (reset) begin
            mc     <= 0;
            mvalid <= 1'b1;
        end else if (!bus.data_island_period) begin
            mc <= 0;
        end else begin
            mc <= (mc + 1) % 32;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_pixel) begin
        if (mvalid) begin
            logic       ee;
            logic [8:0] ed;
            ee = bus.data_island_period && !reset && (mc == 31);
            ed = bus.data_island_period ? model_data(mc, bus.header, bus.sub) : 9'h000;
            check("counter", 32'(bus.packet_pixel_counter), 32'(mc));
            check("enable", 32'(bus.packet_enable), 32'(ee));
            check("data", 32'(bus.packet_data), 32'(ed));
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic run_pixels(input int n, output int en_cnt, output int en_last);
        en_cnt  = 0;
        en_last = -1;
        for (int i = 0; i < n; i++) begin
            #1;
            if (bus.packet_enable) begin
                en_cnt++;
                en_last = i;
            end
            tick();
        end
    endtask

    task automatic randomize_packet();
        bus.header = 24'($urandom());
        for (int k = 0; k < 4; k++) begin
            bus.sub[k] = 56'({$urandom(), $urandom()});
        end
    endtask

    initial begin
        int         n;
        int         last;
        logic [7:0] ecc_lit;
        logic [23:0] hsave;

        reset                  = 1'b1;
        bus.data_island_period = 1'b0;
        bus.header             = '0;
        bus.sub                = '0;
        repeat (3) tick();
        check("rst_counter", 32'(bus.packet_pixel_counter), 32'd0);
        check("rst_enable", 32'(bus.packet_enable), 32'd0);
        check("rst_data", 32'(bus.packet_data), 32'd0);
        reset = 1'b0;
        tick();

        // All-zero packet.
        bus.data_island_period = 1'b1;
        run_pixels(32, n, last);
        check("zero_en_count", 32'(n), 32'd1);
        check("zero_en_at", 32'(last), 32'd31);

        // header = 1: ECC 8'h4A appears LSB first on pixels 24..31.
        bus.data_island_period = 1'b0;
        tick();
        bus.header             = 24'h000001;
        bus.data_island_period = 1'b1;
        ecc_lit                = 8'h4A;
        for (int i = 0; i < 32; i++) begin
            #1;
            check("hdr1_counter", 32'(bus.packet_pixel_counter), 32'(i));
            if (i >= 24) check("hdr1_ecc_bit", 32'(bus.packet_data[0]), 32'(ecc_lit[i - 24]));
            tick();
        end

        // Two back-to-back random packets.
        randomize_packet();
        run_pixels(32, n, last);
        check("b2b1_en_at", 32'(last), 32'd31);
        randomize_packet();
        run_pixels(32, n, last);
        check("b2b2_en_count", 32'(n), 32'd1);

        // Island dropped at pixel 10, then a fresh packet.
        randomize_packet();
        run_pixels(10, n, last);
        bus.data_island_period = 1'b0;
        run_pixels(3, n, last);
        check("abort_en_count", 32'(n), 32'd0);
        bus.data_island_period = 1'b1;
        randomize_packet();
        run_pixels(32, n, last);
        check("after_abort_en_at", 32'(last), 32'd31);

        // Reset at pixel 20 with the island still high.
        randomize_packet();
        run_pixels(20, n, last);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        hsave = bus.header;
        check("rst_mid_counter", 32'(bus.packet_pixel_counter), 32'd0);
        check("rst_mid_data0", 32'(bus.packet_data[0]), 32'(hsave[0]));
        run_pixels(32, n, last);
        check("rst_mid_en_count", 32'(n), 32'd1);
        check("rst_mid_en_at", 32'(last), 32'd31);

        bus.data_island_period = 1'b0;
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
